// File: rtl/player_plot_scheduler.sv
// Snapshots player positions on each tick and streams one plot request per live, on-screen
// player to the VGA adapter; also runs a full-screen clear sweep.
module player_plot_scheduler #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7,
  parameter int unsigned COL_W = 3,
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119,
  parameter logic [NUM_PLAYERS*COL_W-1:0] PLAYER_COLOURS = {3'b110, 3'b100, 3'b010, 3'b001},
  parameter logic [COL_W-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] pos,
  input  logic [NUM_PLAYERS-1:0]           alive,
  input  logic                             tick,
  input  logic                             clear_req,
  input  logic                             plot_ready,
  output logic [X_W-1:0]                   x,
  output logic [Y_W-1:0]                   y,
  output logic [COL_W-1:0]                 colour,
  output logic                             plot,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun
);
  localparam int unsigned XY_W = X_W + Y_W;
  localparam int unsigned IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, CLEAR = 2'd2, FINISH = 2'd3} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_PLAYERS*XY_W-1:0]     snap_pos_q, snap_pos_d;
  logic [NUM_PLAYERS-1:0]          snap_alive_q, snap_alive_d;
  logic [X_W-1:0]                  x_q, x_d;
  logic [Y_W-1:0]                  y_q, y_d;
  logic [COL_W-1:0]                colour_q, colour_d;
  logic                            plot_q, plot_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            overrun_q, overrun_d;

  logic                            load_s;
  logic [IDX_W-1:0]                cand_idx_s;
  logic [NUM_PLAYERS*XY_W-1:0]     cand_pos_s;
  logic [NUM_PLAYERS-1:0]          cand_alive_s;
  logic [XY_W-1:0]                 cand_xy_s;

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_pos_d   = snap_pos_q;
    snap_alive_d = snap_alive_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = plot_q;
    load_s       = 1'b0;
    cand_idx_s   = idx_q;
    cand_pos_s   = snap_pos_q;
    cand_alive_s = snap_alive_q;
    cand_xy_s    = '0;

    case (state_q)
      IDLE: begin
        plot_d = 1'b0;
        if (clear_req) begin
          state_d  = CLEAR;
          x_d      = '0;
          y_d      = '0;
          colour_d = CLEAR_COLOUR;
          plot_d   = 1'b1;
        end else if (tick) begin
          // Evaluate player 0 straight from the inputs being captured this edge
          state_d      = SCAN;
          idx_d        = '0;
          snap_pos_d   = pos;
          snap_alive_d = alive;
          load_s       = 1'b1;
          cand_idx_s   = '0;
          cand_pos_s   = pos;
          cand_alive_s = alive;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!plot_q || plot_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
            plot_d  = 1'b0;
          end else begin
            idx_d      = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            load_s     = 1'b1;
            cand_idx_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = SCAN;
        end
      end
      CLEAR: begin
        if (plot_ready) begin
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            state_d = FINISH;
            plot_d  = 1'b0;
          end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + {{(Y_W-1){1'b0}}, 1'b1};
          end else begin
            x_d = x_q + {{(X_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = CLEAR;
        end
      end
      FINISH: begin
        state_d = IDLE;
        plot_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        plot_d  = 1'b0;
      end
    endcase

    if (load_s) begin
      cand_xy_s = cand_pos_s[int'(cand_idx_s)*XY_W +: XY_W];
      if (cand_alive_s[cand_idx_s] && (cand_xy_s[XY_W-1 -: X_W] <= X_LAST) &&
          (cand_xy_s[Y_W-1:0] <= Y_LAST)) begin
        x_d      = cand_xy_s[XY_W-1 -: X_W];
        y_d      = cand_xy_s[Y_W-1:0];
        colour_d = PLAYER_COLOURS[int'(cand_idx_s)*COL_W +: COL_W];
        plot_d   = 1'b1;
      end else begin
        plot_d = 1'b0;
      end
    end else begin
      cand_xy_s = '0;
    end

    if ((tick || clear_req) && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State, snapshot and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_pos_q   <= '0;
      snap_alive_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_pos_q   <= snap_pos_d;
      snap_alive_q <= snap_alive_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;
endmodule
